// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the loader state encoding, the error codes reported on err_code and
// the default instruction memory size.
package boot_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 32;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } boot_state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream valid/ready link feeding the boot loader.
//   s_valid : source has a byte on s_data
//   s_data  : byte value, held stable while s_valid && !s_ready
//   s_ready : sink accepts the byte this cycle
// master = byte source, slave = loader.
interface imem_boot_loader_if;

  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/boot_csum8.sv
// 8-bit modular checksum accumulator.
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : zero the accumulator (wins over add)
//   add_en     : accumulate din this cycle
//   din        : incoming byte
//   sum_zero   : (acc + din) mod 256 == 0, used to judge the checksum byte
module boot_csum8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] din,
  output logic       sum_zero
);

  logic [7:0] acc_q;
  logic [7:0] sum;

  assign sum      = acc_q + din;
  assign sum_zero = (sum == 8'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= 8'd0;
    end else if (clr) begin
      acc_q <= 8'd0;
    end else if (add_en) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte image and writes
// it into the byte-addressed instruction memory, then releases the CPU.
//   clk, rst_n  : clock and synchronous active-low reset
//   up          : byte stream in (s_valid / s_data / s_ready)
//   reload      : one-cycle pulse, return to waiting for a new image
//   mem_we      : byte write strobe, one cycle per accepted data byte
//   mem_addr    : write byte address
//   mem_wdata   : write byte
//   cpu_run     : image loaded and verified
//   busy        : loading (length, data or checksum phase)
//   err_code    : sticky error (none / bad length / checksum mismatch)
//   loaded_len  : byte count of the last accepted image
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned LEN_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_boot_loader_if.slave    up,
  input  logic                 reload,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 cpu_run,
  output logic                 busy,
  output logic [1:0]           err_code,
  output logic [LEN_W-1:0]     loaded_len
);

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  loaded_len_q, loaded_len_d;
  logic [1:0]        err_q, err_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic xfer;
  logic len_bad;
  logic last_byte;
  logic csum_clr;
  logic csum_add;
  logic csum_ok;

  assign busy       = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  // reload forces ready low so a same-cycle byte is left with the source.
  assign up.s_ready = busy && !reload;
  assign xfer       = up.s_valid && up.s_ready;

  // Length must be nonzero, a whole number of 32-bit words, and fit the memory.
  assign len_bad = (up.s_data == 8'd0) || (up.s_data[1:0] != 2'b00) ||
                   ({24'd0, up.s_data} > MEM_BYTES);

  assign last_byte = (LEN_W'(cnt_q) == (len_q - LEN_W'(1)));

  boot_csum8 u_csum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (csum_clr),
    .add_en   (csum_add),
    .din      (up.s_data),
    .sum_zero (csum_ok)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    err_d        = err_q;
    loaded_len_d = loaded_len_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    csum_clr     = 1'b0;
    csum_add     = 1'b0;

    if (reload) begin
      state_d  = S_LEN;
      err_d    = ERR_NONE;
      cnt_d    = '0;
      csum_clr = 1'b1;
    end else if (xfer) begin
      case (state_q)
        S_LEN: begin
          if (len_bad) begin
            state_d = S_ERR;
            err_d   = ERR_LEN;
          end else begin
            state_d  = S_DATA;
            len_d    = up.s_data[LEN_W-1:0];
            cnt_d    = '0;
            csum_clr = 1'b1;
          end
        end
        S_DATA: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q;
          mem_wdata_d = up.s_data;
          csum_add    = 1'b1;
          cnt_d       = cnt_q + ADDR_W'(1);
          if (last_byte) begin
            state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (csum_ok) begin
            state_d      = S_RUN;
            loaded_len_d = len_q;
          end else begin
            state_d = S_ERR;
            err_d   = ERR_CSUM;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_LEN;
      cnt_q        <= '0;
      len_q        <= '0;
      err_q        <= ERR_NONE;
      loaded_len_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      err_q        <= err_d;
      loaded_len_q <= loaded_len_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_run    = (state_q == S_RUN);
  assign err_code   = err_q;
  assign loaded_len = loaded_len_q;

endmodule
